dmem_param: RTL and testbench

Parametrised, byte-addressed single-port data memory for the single-cycle core's load/store path. It generalises the fixed 32×32 data memory with configurable width and depth, per-byte write enables, a registered read port with a valid strobe, and an alignment/range error flag. After every reset it runs a self-clearing sweep and reports readiness, so the core can stall until the array is known-zero.

---
 rtl/dmem_param.sv | 100 ++++++++++
 tb/tb_dmem_param.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_param.sv
// rtl/dmem_param.sv - byte-addressed data memory with power-up clear sweep; DMEM_WR_FWD_EN forwards same-word writes to reads
module dmem_param #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic [DATA_W/8-1:0]   byteEn,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     data,
    input  logic                  errClr,
    output logic [DATA_W-1:0]     dataOut,
    output logic                  rdValid,
    output logic                  ready,
    output logic                  addrErr
);

    localparam int NB = DATA_W / 8;
    localparam int BL = $clog2(NB);
    localparam int AW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LOW_MASK  = ADDR_W'((64'd1 << BL) - 64'd1);
    localparam logic [ADDR_W-1:0] HIGH_MASK = ~ADDR_W'((64'd1 << (BL + AW)) - 64'd1);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    logic [AW-1:0]     cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     widx;
    logic              bad;
    logic              acc_rd;
    logic              acc_wr;
    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] merged;

    assign widx   = addr[BL+AW-1:BL];
    assign bad    = (|(addr & LOW_MASK)) | (|(addr & HIGH_MASK));
    assign acc_rd = (state == RUN) && memRead && !bad;
    assign acc_wr = (state == RUN) && memWrite && !bad;
    assign cur    = mem[widx];

    always_comb begin
        merged = cur;
        for (int i = 0; i < NB; i++) begin
            if (byteEn[i]) merged[8*i +: 8] = data[8*i +: 8];
        end
    end

    // Array has no reset of its own; the INIT sweep is what makes it known-zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == INIT)
                mem[cnt] <= '0;
            else if (acc_wr)
                mem[widx] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= INIT;
            cnt     <= '0;
            dataOut <= '0;
            rdValid <= 1'b0;
            ready   <= 1'b0;
            addrErr <= 1'b0;
        end else begin
            rdValid <= acc_rd;
            if (acc_rd) begin
`ifdef DMEM_WR_FWD_EN
                dataOut <= memWrite ? merged : cur;
`else
                dataOut <= cur;
`endif
            end

            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(DEPTH - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                default: ;
            endcase

            // A new error wins over a simultaneous clear.
            if ((state == RUN) && (memRead || memWrite) && bad)
                addrErr <= 1'b1;
            else if (errClr)
                addrErr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_param.sv
// tb/tb_dmem_param.sv - randomized and directed checks of dmem_param against an in-bench memory model
module tb_dmem_param;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [3:0]  byteEn = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] data = 32'h0;
    logic        errClr = 1'b0;
    logic [31:0] dataOut;
    logic        rdValid;
    logic        ready;
    logic        addrErr;

    int checks = 0;
    int errors = 0;

    dmem_param #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
        .byteEn(byteEn), .addr(addr), .data(data), .errClr(errClr),
        .dataOut(dataOut), .rdValid(rdValid), .ready(ready), .addrErr(addrErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory as a plain array, readiness as a count of edges since reset.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_out;
    bit          m_valid, m_ready, m_err, m_ok;
    int          m_edges;

    initial m_ok = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            m_ready = 0; m_edges = 0; m_out = 0; m_valid = 0; m_err = 0; m_ok = 1;
        end else if (m_ok) begin
            int unsigned w;
            bit          badr;
            logic [31:0] old, nw;
            w    = addr / 4;
            badr = (addr % 4 != 0) || (addr >= DEPTH * 4);
            m_valid = 0;
            if (m_ready && (memRead || memWrite) && badr)
                m_err = 1;
            else if (errClr)
                m_err = 0;
            if (m_ready && !badr) begin
                old = m_mem[w];
                nw  = old;
                for (int b = 0; b < 4; b++)
                    if (byteEn[b]) nw[8*b +: 8] = data[8*b +: 8];
                if (memRead) begin
                    m_valid = 1;
`ifdef DMEM_WR_FWD_EN
                    m_out = memWrite ? nw : old;
`else
                    m_out = old;
`endif
                end
                if (memWrite) m_mem[w] = nw;
            end
            if (!m_ready) begin
                m_edges++;
                if (m_edges == DEPTH) begin
                    m_ready = 1;
                    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("ready", {31'b0, ready}, {31'b0, m_ready});
            check("rdValid", {31'b0, rdValid}, {31'b0, m_valid});
            check("addrErr", {31'b0, addrErr}, {31'b0, m_err});
            check("dataOut", dataOut, m_out);
        end
    end

    task automatic req(input bit rd, input bit wr, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] d, input bit clr);
        memRead = rd; memWrite = wr; byteEn = be; addr = a; data = d; errClr = clr;
        @(negedge clk);
        memRead = 0; memWrite = 0; byteEn = 0; errClr = 0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, n, DEPTH);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_dataOut", dataOut, 32'h0);
        check("reset_ready", {31'b0, ready}, 32'h0);
        reset = 1;
        wait_ready("sweep_len");

        req(1, 0, 4'h0, 32'hFC, 32'h0, 0);
        check("word63", dataOut, 32'h0);
        check("word63_valid", {31'b0, rdValid}, 32'h1);

        req(0, 1, 4'hF, 32'h08, 32'h01200334, 0);
        req(0, 1, 4'b0101, 32'h08, 32'hAABBCCDD, 0);
        req(1, 0, 4'h0, 32'h08, 32'h0, 0);
        check("byte_en", dataOut, 32'h01BB03DD);

        req(0, 1, 4'hF, 32'h0A, 32'hDEADBEEF, 0);
        check("misalign_err", {31'b0, addrErr}, 32'h1);
        req(0, 1, 4'hF, 32'h100, 32'hDEADBEEF, 0);
        req(1, 0, 4'h0, 32'h08, 32'h0, 0);
        check("err_nowrite", dataOut, 32'h01BB03DD);
        req(0, 0, 4'h0, 32'h0, 32'h0, 1);
        check("err_clr", {31'b0, addrErr}, 32'h0);

        req(0, 1, 4'hF, 32'h14, 32'h11111111, 0);
        req(1, 1, 4'hF, 32'h14, 32'h22222222, 0);
`ifdef DMEM_WR_FWD_EN
        check("rw_same", dataOut, 32'h22222222);
`else
        check("rw_same", dataOut, 32'h11111111);
`endif
        req(1, 0, 4'h0, 32'h14, 32'h0, 0);
        check("rw_after", dataOut, 32'h22222222);

        reset = 0;
        @(negedge clk);
        reset = 1;
        repeat (29) @(negedge clk);
        reset = 0;
        @(negedge clk);
        reset = 1;
        repeat (5) @(negedge clk);
        req(1, 0, 4'h0, 32'h0, 32'h0, 0);
        check("init_rd_valid", {31'b0, rdValid}, 32'h0);
        check("init_rd_err", {31'b0, addrErr}, 32'h0);
        reset = 0;
        @(negedge clk);
        reset = 1;
        wait_ready("resweep_len");

        for (int c = 0; c < 3000; c++) begin
            int unsigned r = $urandom % 16;
            memRead  = $urandom % 2;
            memWrite = $urandom % 2;
            byteEn   = 4'($urandom);
            data     = $urandom;
            errClr   = ($urandom % 8) == 0;
            if (r == 0)      addr = 32'($urandom % 256) | 32'h1;
            else if (r == 1) addr = 32'h100 + 32'($urandom % 1024);
            else if (r < 10) addr = 32'(($urandom % 8) * 4);
            else             addr = 32'(($urandom % DEPTH) * 4);
            reset = !(($urandom % 700) == 0);
            @(negedge clk);
        end
        reset = 1; memRead = 0; memWrite = 0; errClr = 0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
